// File: rtl/register_arbiter.sv
// Round-robin arbiter feeding a 4-input loadable register: picks a producer,
// drives load/select/ack with zero latency and tracks one-deep occupancy.
module register_arbiter #(
   parameter int unsigned burst = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] ack,
   output logic       load,
   output logic [1:0] select,
   output logic       valid,
   input  logic       ready
);

   localparam logic [7:0] burst_lim = 8'(burst);

   logic       valid_r;
   logic [1:0] ptr_r;
   logic [7:0] cnt_r;

   logic       space_s;
   logic       grant_s;
   logic [1:0] win_s;
   logic [7:0] cnt_next_s;

   // First requester found scanning p, p+1, p+2, p+3 (mod 4); the scan runs
   // from the farthest offset down so the nearest requester is written last.
   function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] w;
      logic [1:0] idx;
      w = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         w   = r[idx] ? idx : w;
      end
      return w;
   endfunction

   assign valid = valid_r;

   // Grant decision and register-side controls, all combinational.
   always_comb begin
      space_s    = !valid_r || ready;
      grant_s    = space_s && (req != 4'b0000) && !reset;
      win_s      = pick_winner(req, ptr_r);
      cnt_next_s = (win_s == ptr_r) ? (cnt_r + 8'd1) : 8'd1;
      if (grant_s) begin
         load   = 1'b1;
         select = win_s;
         ack    = 4'b0001 << win_s;
      end else begin
         load   = 1'b0;
         select = reset ? 2'b00 : ptr_r;
         ack    = 4'b0000;
      end
   end

   // Occupancy flag plus priority pointer and burst counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_r <= 1'b0;
         ptr_r   <= 2'b00;
         cnt_r   <= 8'd0;
      end else begin
         if (grant_s) begin
            valid_r <= 1'b1;
         end else if (valid_r && ready) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
         // A winner that exhausts its burst hands priority to the next slot.
         if (grant_s) begin
            if (cnt_next_s >= burst_lim) begin
               ptr_r <= win_s + 2'd1;
               cnt_r <= 8'd0;
            end else begin
               ptr_r <= win_s;
               cnt_r <= cnt_next_s;
            end
         end else begin
            ptr_r <= ptr_r;
            cnt_r <= cnt_r;
         end
      end
   end

endmodule
